// File: rtl/arcade_input_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | arcade_input_pkg                                                      |
// | Button bit map, PS/2 scan codes and coin FSM encoding for the hub.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package arcade_input_pkg;

    localparam int C_BTN_RIGHT  = 0;
    localparam int C_BTN_LEFT   = 1;
    localparam int C_BTN_DOWN   = 2;
    localparam int C_BTN_UP     = 3;
    localparam int C_BTN_FIRE   = 4;
    localparam int C_BTN_START  = 5;
    localparam int C_BTN_SELECT = 6;
    localparam int C_BTN_COIN   = 7;

    // Arrow codes are matched with or without the E0 prefix
    localparam logic [7:0] C_SC_UP       = 8'h75;
    localparam logic [7:0] C_SC_DOWN     = 8'h72;
    localparam logic [7:0] C_SC_LEFT     = 8'h6B;
    localparam logic [7:0] C_SC_RIGHT    = 8'h74;
    localparam logic [7:0] C_SC_FIRE1_A  = 8'h29;
    localparam logic [7:0] C_SC_FIRE1_B  = 8'h14;
    localparam logic [7:0] C_SC_START1_A = 8'h05;
    localparam logic [7:0] C_SC_START1_B = 8'h16;
    localparam logic [7:0] C_SC_START2_A = 8'h06;
    localparam logic [7:0] C_SC_START2_B = 8'h1E;
    localparam logic [7:0] C_SC_COIN1    = 8'h2E;
    localparam logic [7:0] C_SC_COIN2    = 8'h36;
    localparam logic [7:0] C_SC_P2_UP    = 8'h2D;
    localparam logic [7:0] C_SC_P2_DOWN  = 8'h2B;
    localparam logic [7:0] C_SC_P2_LEFT  = 8'h23;
    localparam logic [7:0] C_SC_P2_RIGHT = 8'h34;
    localparam logic [7:0] C_SC_P2_FIRE  = 8'h1C;
    localparam logic [7:0] C_SC_TEST     = 8'h2C;

    typedef logic [0:0] coin_state_t;
    localparam coin_state_t C_COIN_IDLE  = 1'b0;
    localparam coin_state_t C_COIN_PULSE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/coin_pulse_stretcher.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | coin_pulse_stretcher                                                  |
// | Turns a coin rising edge into a pulse exactly WIDTH_CYCLES long.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module coin_pulse_stretcher
    import arcade_input_pkg::*;
#(
    parameter int WIDTH_CYCLES = 1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_coin_raw,
    output logic o_pulse
);

    localparam int              C_CW   = $clog2(WIDTH_CYCLES);
    localparam logic [C_CW-1:0] C_LOAD = C_CW'(WIDTH_CYCLES - 1);

    coin_state_t     r_state;
    coin_state_t     w_state_nxt;
    logic [C_CW-1:0] r_cnt;
    logic            r_coin_d;
    logic            r_pulse;
    logic            w_pulse_nxt;
    logic            w_rise;

    // The edge history keeps tracking through reset so a coin held across
    // reset never counts as a fresh insertion.
    always_ff @(posedge clk) begin
        r_coin_d <= i_coin_raw;
    end

    assign w_rise = i_coin_raw & ~r_coin_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_COIN_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_COIN_IDLE:  if (w_rise) w_state_nxt = C_COIN_PULSE;
            C_COIN_PULSE: if (r_cnt == '0) w_state_nxt = C_COIN_IDLE;
            default:      w_state_nxt = C_COIN_IDLE;
        endcase
    end

    always_comb begin
        w_pulse_nxt = (r_state == C_COIN_PULSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_pulse_nxt;
            if (r_state == C_COIN_IDLE && w_rise) begin
                r_cnt <= C_LOAD;
            end else if (r_state == C_COIN_PULSE && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/arcade_input_hub.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | arcade_input_hub                                                      |
// | Config latch, PS/2 key decode, joystick merge, coin stretch, autofire.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module arcade_input_hub
    import arcade_input_pkg::*;
#(
    parameter int NUM_DIP_BYTES = 8,
    parameter int MOD_INDEX     = 1,
    parameter int DIP_INDEX     = 254,
    parameter int COIN_PULSE    = 1200000,
    parameter int AUTOFIRE_DIV  = 600000
) (
    input  logic                       clk_sys,
    input  logic                       RESET,
    input  logic                       ioctl_wr,
    input  logic [7:0]                 ioctl_index,
    input  logic [24:0]                ioctl_addr,
    input  logic [7:0]                 ioctl_dout,
    input  logic [10:0]                ps2_key,
    input  logic [15:0]                joystick_0,
    input  logic [15:0]                joystick_1,
    input  logic                       autofire_en,
    output logic [7:0]                 mod_id,
    output logic [8*NUM_DIP_BYTES-1:0] dip,
    output logic [7:0]                 p1_btn,
    output logic [7:0]                 p2_btn,
    output logic                       coin_pulse,
    output logic                       btn_test
);

    localparam int C_AFW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
    localparam logic [C_AFW-1:0] C_AF_LAST = C_AFW'(AUTOFIRE_DIV - 1);

    // Configuration survives game reset; only the power-up value is defined.
    logic [7:0] r_mod_id = 8'h00;
    logic       w_dip_hit;

    always_ff @(posedge clk_sys) begin
        if (ioctl_wr && ioctl_index == 8'(MOD_INDEX)) begin
            r_mod_id <= ioctl_dout;
        end
    end

    assign w_dip_hit = ioctl_wr && (ioctl_index == 8'(DIP_INDEX)) &&
                       (ioctl_addr[24:5] == '0) &&
                       (32'(ioctl_addr[4:0]) < NUM_DIP_BYTES);

    for (genvar gv_k = 0; gv_k < NUM_DIP_BYTES; gv_k++) begin : g_dip
        logic [7:0] r_byte = 8'hFF;
        always_ff @(posedge clk_sys) begin
            if (w_dip_hit && ioctl_addr[4:0] == 5'(gv_k)) begin
                r_byte <= ioctl_dout;
            end
        end
        assign dip[8*gv_k +: 8] = r_byte;
    end

    logic       r_old_toggle;
    logic [7:0] r_p1_key, w_p1_key;
    logic [7:0] r_p2_key, w_p2_key;
    logic [1:0] r_coin_key, w_coin_key;
    logic       r_test_key, w_test_key;
    logic       w_ps2_evt;

    assign w_ps2_evt = (ps2_key[10] != r_old_toggle);

    always_comb begin
        w_p1_key   = r_p1_key;
        w_p2_key   = r_p2_key;
        w_coin_key = r_coin_key;
        w_test_key = r_test_key;
        if (w_ps2_evt) begin
            case (ps2_key[7:0])
                C_SC_UP:    w_p1_key[C_BTN_UP]    = ps2_key[9];
                C_SC_DOWN:  w_p1_key[C_BTN_DOWN]  = ps2_key[9];
                C_SC_LEFT:  w_p1_key[C_BTN_LEFT]  = ps2_key[9];
                C_SC_RIGHT: w_p1_key[C_BTN_RIGHT] = ps2_key[9];
                default: ;
            endcase
            if (!ps2_key[8]) begin
                case (ps2_key[7:0])
                    C_SC_FIRE1_A, C_SC_FIRE1_B:   w_p1_key[C_BTN_FIRE]  = ps2_key[9];
                    C_SC_START1_A, C_SC_START1_B: w_p1_key[C_BTN_START] = ps2_key[9];
                    C_SC_START2_A, C_SC_START2_B: w_p2_key[C_BTN_START] = ps2_key[9];
                    C_SC_COIN1:    w_coin_key[0]          = ps2_key[9];
                    C_SC_COIN2:    w_coin_key[1]          = ps2_key[9];
                    C_SC_P2_UP:    w_p2_key[C_BTN_UP]     = ps2_key[9];
                    C_SC_P2_DOWN:  w_p2_key[C_BTN_DOWN]   = ps2_key[9];
                    C_SC_P2_LEFT:  w_p2_key[C_BTN_LEFT]   = ps2_key[9];
                    C_SC_P2_RIGHT: w_p2_key[C_BTN_RIGHT]  = ps2_key[9];
                    C_SC_P2_FIRE:  w_p2_key[C_BTN_FIRE]   = ps2_key[9];
                    C_SC_TEST:     w_test_key             = ps2_key[9];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_old_toggle <= ps2_key[10];
            r_p1_key     <= '0;
            r_p2_key     <= '0;
            r_coin_key   <= '0;
            r_test_key   <= 1'b0;
        end else begin
            r_old_toggle <= ps2_key[10];
            r_p1_key     <= w_p1_key;
            r_p2_key     <= w_p2_key;
            r_coin_key   <= w_coin_key;
            r_test_key   <= w_test_key;
        end
    end

    logic [C_AFW-1:0] r_af_cnt;
    logic             r_af_phase;

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b1;
        end else if (r_af_cnt == C_AF_LAST) begin
            r_af_cnt   <= '0;
            r_af_phase <= ~r_af_phase;
        end else begin
            r_af_cnt   <= r_af_cnt + 1'b1;
        end
    end

    logic [7:0] w_p1_mrg, w_p2_mrg;
    logic [7:0] r_p1_btn, r_p2_btn;
    logic       r_btn_test;

    always_comb begin
        w_p1_mrg = r_p1_key | joystick_0[7:0];
        w_p2_mrg = r_p2_key | joystick_1[7:0];
        w_p2_mrg[C_BTN_START] = w_p2_mrg[C_BTN_START] | joystick_0[C_BTN_SELECT];
        if (autofire_en) begin
            w_p1_mrg[C_BTN_FIRE] = w_p1_mrg[C_BTN_FIRE] & r_af_phase;
            w_p2_mrg[C_BTN_FIRE] = w_p2_mrg[C_BTN_FIRE] & r_af_phase;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_p1_btn   <= '0;
            r_p2_btn   <= '0;
            r_btn_test <= 1'b0;
        end else begin
            r_p1_btn   <= w_p1_mrg;
            r_p2_btn   <= w_p2_mrg;
            r_btn_test <= r_test_key;
        end
    end

    logic w_coin_raw;
    assign w_coin_raw = (|r_coin_key) | joystick_0[C_BTN_COIN] | joystick_1[C_BTN_COIN];

    coin_pulse_stretcher #(
        .WIDTH_CYCLES (COIN_PULSE)
    ) u_coin (
        .clk        (clk_sys),
        .rst        (RESET),
        .i_coin_raw (w_coin_raw),
        .o_pulse    (coin_pulse)
    );

    logic w_unused;
    assign w_unused = &{1'b0, joystick_0[15:8], joystick_1[15:8]};

    assign mod_id   = r_mod_id;
    assign p1_btn   = r_p1_btn;
    assign p2_btn   = r_p2_btn;
    assign btn_test = r_btn_test;

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_hub.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_arcade_input_hub                                                   |
// | Directed and random stimulus against a cycle-level behavioural model. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_arcade_input_hub;

    localparam int NDIP = 8;
    localparam int CP   = 10;
    localparam int AFD  = 4;

    localparam int K_UP = 0, K_DOWN = 1, K_LEFT = 2, K_RIGHT = 3, K_FIRE1 = 4,
                   K_START1 = 5, K_START2 = 6, K_COIN1 = 7, K_COIN2 = 8,
                   K_P2UP = 9, K_P2DOWN = 10, K_P2LEFT = 11, K_P2RIGHT = 12,
                   K_FIRE2 = 13, K_TEST = 14;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic              RESET;
    logic              ioctl_wr;
    logic [7:0]        ioctl_index;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [10:0]       ps2_key;
    logic [15:0]       joystick_0, joystick_1;
    logic              autofire_en;
    logic [7:0]        mod_id;
    logic [8*NDIP-1:0] dip;
    logic [7:0]        p1_btn, p2_btn;
    logic              coin_pulse, btn_test;

    arcade_input_hub #(
        .NUM_DIP_BYTES (NDIP), .MOD_INDEX (1), .DIP_INDEX (254),
        .COIN_PULSE (CP), .AUTOFIRE_DIV (AFD)
    ) dut (
        .clk_sys (clk_sys), .RESET (RESET), .ioctl_wr (ioctl_wr),
        .ioctl_index (ioctl_index), .ioctl_addr (ioctl_addr), .ioctl_dout (ioctl_dout),
        .ps2_key (ps2_key), .joystick_0 (joystick_0), .joystick_1 (joystick_1),
        .autofire_en (autofire_en), .mod_id (mod_id), .dip (dip),
        .p1_btn (p1_btn), .p2_btn (p2_btn), .coin_pulse (coin_pulse), .btn_test (btn_test)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] m_mod = 8'h00;
    logic [7:0] m_dip [NDIP];
    bit         key [15];
    bit         m_old = 1'b0;
    int         af_t = 0;
    int         edge_n = 0;
    bit         coin_act = 1'b0;
    int         coin_start = 0;
    bit         raw_prev = 1'b0;
    bit         armed = 1'b0;
    int         pulse_hi = 0;

    function automatic int key_of(input logic [8:0] c);
        case (c[7:0])
            8'h75: return K_UP;
            8'h72: return K_DOWN;
            8'h6B: return K_LEFT;
            8'h74: return K_RIGHT;
            default: ;
        endcase
        if (c[8]) return -1;
        case (c[7:0])
            8'h29, 8'h14: return K_FIRE1;
            8'h05, 8'h16: return K_START1;
            8'h06, 8'h1E: return K_START2;
            8'h2E: return K_COIN1;
            8'h36: return K_COIN2;
            8'h2D: return K_P2UP;
            8'h2B: return K_P2DOWN;
            8'h23: return K_P2LEFT;
            8'h34: return K_P2RIGHT;
            8'h1C: return K_FIRE2;
            8'h2C: return K_TEST;
            default: return -1;
        endcase
    endfunction

    function automatic logic [63:0] pack_dip();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NDIP; i++) v[8*i +: 8] = m_dip[i];
        return v;
    endfunction

    // One clock: predict from the state before the edge, advance, compare.
    task automatic tick();
        logic [7:0] e1, e2;
        logic       e_test, e_pulse;
        bit         raw, ph;
        int         k;
        edge_n++;
        raw = key[K_COIN1] | key[K_COIN2] | joystick_0[7] | joystick_1[7];
        ph  = ((af_t / AFD) % 2) == 0;
        e1 = joystick_0[7:0] | {2'b00, key[K_START1], key[K_FIRE1], key[K_UP],
                                key[K_DOWN], key[K_LEFT], key[K_RIGHT]};
        e2 = joystick_1[7:0] | {2'b00, key[K_START2] | joystick_0[6], key[K_FIRE2],
                                key[K_P2UP], key[K_P2DOWN], key[K_P2LEFT], key[K_P2RIGHT]};
        if (autofire_en && !ph) begin
            e1[4] = 1'b0;
            e2[4] = 1'b0;
        end
        e_test = key[K_TEST];
        if (RESET) begin
            coin_act = 1'b0;
        end else if (raw && !raw_prev && !(coin_act && edge_n <= coin_start + CP)) begin
            coin_act   = 1'b1;
            coin_start = edge_n;
        end
        e_pulse  = coin_act && (edge_n >= coin_start + 1) && (edge_n <= coin_start + CP);
        raw_prev = raw;
        if (RESET) begin
            for (int i = 0; i < 15; i++) key[i] = 1'b0;
            m_old = ps2_key[10];
            af_t  = 0;
            e1 = '0; e2 = '0; e_test = 1'b0;
        end else begin
            if (ps2_key[10] != m_old) begin
                m_old = ps2_key[10];
                k = key_of(ps2_key[8:0]);
                if (k >= 0) key[k] = ps2_key[9];
            end
            af_t++;
        end
        if (ioctl_wr && ioctl_index == 8'd1) m_mod = ioctl_dout;
        if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < NDIP) m_dip[ioctl_addr[2:0]] = ioctl_dout;
        @(posedge clk_sys);
        #1;
        if (coin_pulse) pulse_hi++;
        if (armed) begin
            check_eq("mod_id", mod_id, m_mod);
            check_eq("dip", dip, pack_dip());
            check_eq("p1_btn", p1_btn, e1);
            check_eq("p2_btn", p2_btn, e2);
            check_eq("btn_test", btn_test, e_test);
            check_eq("coin_pulse", coin_pulse, e_pulse);
        end
        ioctl_wr = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ps2_ev(input logic [8:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    task automatic cfg_wr(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
        ioctl_index = idx; ioctl_addr = addr; ioctl_dout = d; ioctl_wr = 1'b1;
        tick();
    endtask

    logic [8:0] codes [22] = '{9'h175, 9'h075, 9'h172, 9'h06B, 9'h174, 9'h029, 9'h014,
                                9'h114, 9'h005, 9'h016, 9'h006, 9'h01E, 9'h02E, 9'h036,
                                9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h02C, 9'h12C, 9'h0FF};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NDIP; i++) m_dip[i] = 8'hFF;
        RESET = 1'b1; ioctl_wr = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
        ps2_key = '0; joystick_0 = '0; joystick_1 = '0; autofire_en = 1'b0;
        #1;
        check_eq("pwr_mod_id", mod_id, 8'h00);
        check_eq("pwr_dip", dip, {64{1'b1}});
        tick();
        armed = 1'b1;
        tick();
        RESET = 1'b0;
        tick();

        // Variant byte: last write wins and survives reset
        cfg_wr(8'd1, 25'd3, 8'h05);
        cfg_wr(8'd1, 25'd0, 8'h0C);
        RESET = 1'b1; ticks(2); RESET = 1'b0;
        check_eq("mod_keep", mod_id, 8'h0C);

        // DIP bank: in-range write, out-of-range and high-bit aliases ignored
        cfg_wr(8'd254, 25'd2, 8'hA5);
        cfg_wr(8'd254, 25'd8, 8'h00);
        cfg_wr(8'd254, 25'h22, 8'h11);
        check_eq("dip_a5", dip, 64'hFFFF_FFFF_FFA5_FFFF);

        // Extended up arrow: two-cycle press and release latency
        ps2_ev(9'h175, 1'b1); tick();
        check_eq("up_press_n1", p1_btn[3], 1'b0);
        tick();
        check_eq("up_press_n2", p1_btn[3], 1'b1);
        ps2_ev(9'h175, 1'b0); tick();
        check_eq("up_rel_n1", p1_btn[3], 1'b1);
        tick();
        check_eq("up_rel_n2", p1_btn[3], 1'b0);
        ps2_ev(9'h0FF, 1'b1); ticks(3);
        check_eq("unlisted_p1", p1_btn, 8'h00);
        check_eq("unlisted_p2", p2_btn, 8'h00);

        // Coin key: retrigger during pulse ignored, later press pulses again
        pulse_hi = 0;
        ps2_ev(9'h02E, 1'b1); ticks(3);
        ps2_ev(9'h02E, 1'b0); ticks(4);
        ps2_ev(9'h02E, 1'b1); ticks(1);
        ps2_ev(9'h02E, 1'b0); ticks(20);
        check_eq("coin_single_width", pulse_hi, CP);
        pulse_hi = 0;
        ps2_ev(9'h02E, 1'b1); ticks(2);
        ps2_ev(9'h02E, 1'b0); ticks(16);
        check_eq("coin_second_width", pulse_hi, CP);

        // Autofire square wave on P2 fire, then steady when disabled
        joystick_1[4] = 1'b1; autofire_en = 1'b1;
        pulse_hi = 0;
        begin
            int n_high;
            n_high = 0;
            for (int i = 0; i < 24; i++) begin
                tick();
                if (p2_btn[4]) n_high++;
            end
            check_eq("af_duty", n_high, 12);
        end
        autofire_en = 1'b0; ticks(2);
        check_eq("af_off", p2_btn[4], 1'b1);
        joystick_1[4] = 1'b0; tick();

        // Reset mid-pulse with coin held: outputs clear, no retrigger
        joystick_0[7] = 1'b1; ticks(4);
        RESET = 1'b1; tick();
        check_eq("rst_coin", coin_pulse, 1'b0);
        check_eq("rst_p1", p1_btn, 8'h00);
        RESET = 1'b0;
        pulse_hi = 0;
        ticks(15);
        check_eq("rst_no_retrig", pulse_hi, 0);
        joystick_0[7] = 1'b0; ticks(2);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            RESET = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       ioctl_index = 8'd1;
                    1, 2:    ioctl_index = 8'd254;
                    default: ioctl_index = 8'd7;
                endcase
                case ($urandom_range(0, 2))
                    0:       ioctl_addr = 25'($urandom_range(0, 7));
                    1:       ioctl_addr = 25'($urandom_range(8, 31));
                    default: ioctl_addr = 25'($urandom_range(0, 7)) | (25'd1 << $urandom_range(5, 24));
                endcase
                ioctl_dout = 8'($urandom);
                ioctl_wr   = 1'b1;
            end
            if ($urandom_range(0, 99) < 15) begin
                if ($urandom_range(0, 4) != 0) ps2_ev(codes[$urandom_range(0, 21)], 1'($urandom));
                else ps2_ev(9'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 9) == 0) joystick_0[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) joystick_1[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 49) == 0) autofire_en = ~autofire_en;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
